// File: rtl/prio_seg_pkg.sv
// Shared constants for the priority-encoder / 7-segment scan block.
// Segment bytes are {a,b,c,d,e,f,g,dp}, bit 7 = a, active-low, dp always off.
package prio_seg_pkg;

   localparam int unsigned SEG_W = 8;

   localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
   localparam logic [SEG_W-1:0] SEG_DASH  = 8'hFD;

   // Hex glyphs 0..F; the first list entry lands at index 15 (F).
   localparam logic [15:0][SEG_W-1:0] SEG_HEX = {
      8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
      8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
   };

   function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nibble);
      return SEG_HEX[nibble];
   endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational nibble -> active-low 7-segment pattern. Dash beats blank.
module seg_hex_dec
   import prio_seg_pkg::*;
(
   input  logic [3:0]       nibble_i,
   input  logic             blank_i,
   input  logic             dash_i,
   output logic [SEG_W-1:0] seg_o
);

   // Select glyph: dash for invalid data, blank for suppressed digits, else hex.
   always_comb begin
      if (dash_i) begin
         seg_o = SEG_DASH;
      end else if (blank_i) begin
         seg_o = SEG_BLANK;
      end else begin
         seg_o = hex_to_seg(nibble_i);
      end
   end

endmodule

// File: rtl/prio_seg_scan.sv
// Priority encoder with registered index, feeding a frame-coherent multiplexed
// hex display. Optional macro PSS_LEADING_BLANK_EN blanks digits above the most
// significant non-zero nibble of a valid snapshot (digit 0 never blanked).
module prio_seg_scan
   import prio_seg_pkg::*;
#(
   parameter int unsigned N_IN     = 16,
   parameter int unsigned IDX_W    = $clog2(N_IN),
   parameter int unsigned N_DIG    = 4,
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [N_IN-1:0]  i_code,
   output logic [IDX_W-1:0] o_code,
   output logic             o_valid,
   output logic [SEG_W-1:0] o_seg,
   output logic [N_DIG-1:0] o_an,
   output logic             o_frame
);

   localparam int unsigned DIG_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   // Wide enough to hold the code and one nibble per digit.
   localparam int unsigned EXT_W = (4 * N_DIG > IDX_W) ? 4 * N_DIG : IDX_W;

   logic [IDX_W-1:0] code_q, enc_code;
   logic             valid_q, enc_valid;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIG_W-1:0] dig_q, dig_d;
   logic             started_q;
   logic             frame_q, frame_d;
   logic             snap_valid_q, snap_valid_d;
   logic [IDX_W-1:0] snap_code_q, snap_code_d;
   logic [SEG_W-1:0] seg_q, seg_d;
   logic [N_DIG-1:0] an_q, an_d;
   logic [EXT_W-1:0] ext;
   logic [3:0]       nibble;
   logic             blank;

   // Encoder: highest set bit wins (later loop iterations overwrite lower ones).
   always_comb begin
      enc_code  = '0;
      enc_valid = 1'b0;
      if (i_en) begin
         for (int i = 0; i < N_IN; i++) begin
            if (i_code[i]) enc_code = IDX_W'(i);
         end
         enc_valid = |i_code;
      end
   end

   // Scan sequencing: first post-reset edge selects digit 0, then advance on terminal count.
   always_comb begin
      cnt_d   = cnt_q;
      dig_d   = dig_q;
      frame_d = 1'b0;
      if (!started_q) begin
         cnt_d   = '0;
         dig_d   = '0;
         frame_d = 1'b1;
      end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
         cnt_d = '0;
         if (dig_q == DIG_W'(N_DIG - 1)) begin
            dig_d   = '0;
            frame_d = 1'b1;
         end else begin
            dig_d = dig_q + 1'b1;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Snapshot the registered encoder result at frame start; hold it for the whole frame.
   always_comb begin
      snap_valid_d = snap_valid_q;
      snap_code_d  = snap_code_q;
      if (frame_d) begin
         snap_valid_d = valid_q;
         snap_code_d  = code_q;
      end
   end

   // Digit content for the digit being selected on this edge, from the new snapshot.
   always_comb begin
      ext    = EXT_W'(snap_code_d);
      nibble = ext[{dig_d, 2'b00} +: 4];
`ifdef PSS_LEADING_BLANK_EN
      begin
         logic [DIG_W-1:0] msn;
         msn = '0;
         for (int d = 0; d < N_DIG; d++) begin
            if (ext[d*4 +: 4] != 4'h0) msn = DIG_W'(d);
         end
         blank = (dig_d > msn);
      end
`else
      blank = 1'b0;
`endif
      an_d = ~(N_DIG'(1) << dig_d);
   end

   seg_hex_dec u_seg_hex_dec (
      .nibble_i (nibble),
      .blank_i  (blank),
      .dash_i   (!snap_valid_d),
      .seg_o    (seg_d)
   );

   // State and registered outputs; synchronous reset dominates everything.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         code_q       <= '0;
         valid_q      <= 1'b0;
         cnt_q        <= '0;
         dig_q        <= '0;
         started_q    <= 1'b0;
         frame_q      <= 1'b0;
         snap_valid_q <= 1'b0;
         snap_code_q  <= '0;
         seg_q        <= SEG_BLANK;
         an_q         <= '1;
      end else begin
         code_q       <= enc_code;
         valid_q      <= enc_valid;
         cnt_q        <= cnt_d;
         dig_q        <= dig_d;
         started_q    <= 1'b1;
         frame_q      <= frame_d;
         snap_valid_q <= snap_valid_d;
         snap_code_q  <= snap_code_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
      end
   end

   assign o_code  = code_q;
   assign o_valid = valid_q;
   assign o_seg   = seg_q;
   assign o_an    = an_q;
   assign o_frame = frame_q;

endmodule

// File: tb/tb_prio_seg_scan.sv
// Self-checking bench: vector table, hand sequences and random stimulus against a
// time-indexed reference model. Two DUTs: SCAN_DIV=4 and SCAN_DIV=1.
module tb_prio_seg_scan;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_en = 1'b0;
   logic [15:0] i_code = '0;
   logic [3:0]  o_code0, o_code1;
   logic        o_valid0, o_valid1;
   logic [7:0]  o_seg0, o_seg1;
   logic [3:0]  o_an0, o_an1;
   logic        o_frame0, o_frame1;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef PSS_LEADING_BLANK_EN
   localparam logic [7:0] LEAD_SEG = 8'hFF;
`else
   localparam logic [7:0] LEAD_SEG = 8'h03;
`endif

   always #5 i_clk = ~i_clk;

   prio_seg_scan #(.N_IN(16), .N_DIG(4), .SCAN_DIV(4)) dut0 (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_code(i_code),
      .o_code(o_code0), .o_valid(o_valid0), .o_seg(o_seg0), .o_an(o_an0), .o_frame(o_frame0)
   );

   prio_seg_scan #(.N_IN(16), .N_DIG(4), .SCAN_DIV(1)) dut1 (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_code(i_code),
      .o_code(o_code1), .o_valid(o_valid1), .o_seg(o_seg1), .o_an(o_an1), .o_frame(o_frame1)
   );

   // Reference model state
   int         k = 0;            // edges since reset release
   logic [3:0] m_code = '0;
   logic       m_valid = 1'b0;
   logic       m_sv [2];
   logic [3:0] m_sc [2];
   logic [7:0] e_seg [2];
   logic [3:0] e_an [2];
   logic       e_frame [2];
   int         sdiv [2];

   function automatic logic [7:0] glyph(input int n);
      case (n)
         0: return 8'h03;  1: return 8'h9F;  2: return 8'h25;  3: return 8'h0D;
         4: return 8'h99;  5: return 8'h49;  6: return 8'h41;  7: return 8'h1F;
         8: return 8'h01;  9: return 8'h09;  10: return 8'h11; 11: return 8'hC1;
         12: return 8'h63; 13: return 8'h85; 14: return 8'h61; default: return 8'h71;
      endcase
   endfunction

   // floor(log2(v)) for v > 0
   function automatic int top_bit(input int v);
      int n = 0;
      while (v > 1) begin
         v = v >> 1;
         n++;
      end
      return n;
   endfunction

   function automatic logic [7:0] m_seg(input int d, input logic v, input int code);
      if (!v) return 8'hFD;
`ifdef PSS_LEADING_BLANK_EN
      if (d > 0 && (code >> (4 * d)) == 0) return 8'hFF;
`endif
      return glyph((code >> (4 * d)) & 15);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // One clock: advance model on the edge, then compare every output 1 time unit later.
   task automatic step();
      logic       nv;
      logic [3:0] nc;
      nv = i_en && (i_code != 16'h0);
      nc = nv ? 4'(top_bit(int'(i_code))) : 4'h0;
      @(posedge i_clk);
      if (i_rst) begin
         k = 0;
         m_code = '0;
         m_valid = 1'b0;
         for (int j = 0; j < 2; j++) begin
            m_sv[j] = 1'b0;
            m_sc[j] = '0;
            e_seg[j] = 8'hFF;
            e_an[j] = 4'hF;
            e_frame[j] = 1'b0;
         end
      end else begin
         k++;
         for (int j = 0; j < 2; j++) begin
            int d;
            logic fr;
            d = ((k - 1) / sdiv[j]) % 4;
            fr = ((k - 1) % (sdiv[j] * 4)) == 0;
            if (fr) begin
               m_sv[j] = m_valid;
               m_sc[j] = m_code;
            end
            e_frame[j] = fr;
            e_an[j] = ~(4'b0001 << d);
            e_seg[j] = m_seg(d, m_sv[j], int'(m_sc[j]));
         end
         m_code = nc;
         m_valid = nv;
      end
      #1;
      chk("code", 32'(o_code0), 32'(m_code));
      chk("valid", 32'(o_valid0), 32'(m_valid));
      chk("seg_div4", 32'(o_seg0), 32'(e_seg[0]));
      chk("an_div4", 32'(o_an0), 32'(e_an[0]));
      chk("frame_div4", 32'(o_frame0), 32'(e_frame[0]));
      chk("seg_div1", 32'(o_seg1), 32'(e_seg[1]));
      chk("an_div1", 32'(o_an1), 32'(e_an[1]));
      chk("frame_div1", 32'(o_frame1), 32'(e_frame[1]));
   endtask

   task automatic wait_frame(input string name);
      for (int i = 0; i < 40; i++) begin
         step();
         if (o_frame0 === 1'b1) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL %s: no frame pulse within 40 cycles, got 0 expected 1", name);
   endtask

   typedef struct {
      logic        en;
      logic [15:0] code;
      logic [3:0]  exp_code;
      logic        exp_valid;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int fc0, fc1;
      sdiv[0] = 4;
      sdiv[1] = 1;
      vecs[0] = '{1'b1, 16'h8001, 4'd15, 1'b1};
      vecs[1] = '{1'b0, 16'hFFFF, 4'd0,  1'b0};
      vecs[2] = '{1'b1, 16'h0000, 4'd0,  1'b0};
      vecs[3] = '{1'b1, 16'h0001, 4'd0,  1'b1};
      vecs[4] = '{1'b1, 16'h0800, 4'd11, 1'b1};
      vecs[5] = '{1'b1, 16'h0002, 4'd1,  1'b1};
      vecs[6] = '{1'b1, 16'hFFFF, 4'd15, 1'b1};
      vecs[7] = '{1'b0, 16'h0001, 4'd0,  1'b0};

      // Reset held 3 cycles
      i_rst = 1'b1;
      i_en = 1'b1;
      i_code = 16'h1234;
      repeat (3) step();
      chk("rst_code", 32'(o_code0), 32'd0);
      chk("rst_valid", 32'(o_valid0), 32'd0);
      chk("rst_seg", 32'(o_seg0), 32'hFF);
      chk("rst_an", 32'(o_an0), 32'hF);
      chk("rst_frame", 32'(o_frame0), 32'd0);

      // First post-reset edge: digit 0, frame pulse, snapshot of reset state
      i_rst = 1'b0;
      i_code = 16'h0090;
      step();
      chk("enc_0090", 32'(o_code0), 32'd7);
      chk("enc_0090_valid", 32'(o_valid0), 32'd1);
      chk("first_frame", 32'(o_frame0), 32'd1);
      chk("first_an", 32'(o_an0), 32'hE);
      chk("first_seg_dash", 32'(o_seg0), 32'hFD);

      // Encoder vector table
      for (int i = 0; i < 8; i++) begin
         i_en = vecs[i].en;
         i_code = vecs[i].code;
         step();
         chk($sformatf("vec%0d_code", i), 32'(o_code0), 32'(vecs[i].exp_code));
         chk($sformatf("vec%0d_valid", i), 32'(o_valid0), 32'(vecs[i].exp_valid));
      end

      // Frame pulse count over 32 cycles
      fc0 = 0;
      fc1 = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (o_frame0) fc0++;
         if (o_frame1) fc1++;
      end
      chk("frames_div4", 32'(fc0), 32'd2);
      chk("frames_div1", 32'(fc1), 32'd8);

      // Random stimulus against the model
      for (int i = 0; i < 300; i++) begin
         i_en = ($urandom_range(0, 7) != 0);
         i_code = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom) >> $urandom_range(0, 15);
         step();
      end

      // Coherence: idx 11 latched, input changes mid-frame
      i_en = 1'b1;
      i_code = 16'h0800;
      step();
      wait_frame("coh_start");
      chk("coh_dig0_B", 32'(o_seg0), 32'hC1);
      i_code = 16'h0002;
      repeat (4) step();
      chk("coh_dig1_an", 32'(o_an0), 32'hD);
      chk("coh_dig1_seg", 32'(o_seg0), 32'(LEAD_SEG));
      wait_frame("coh_next");
      chk("coh_next_dig0", 32'(o_seg0), 32'h9F);
      i_en = 1'b0;
      step();
      wait_frame("coh_invalid");
      chk("invalid_dig0", 32'(o_seg0), 32'hFD);
      repeat (8) step();
      chk("invalid_dig2", 32'(o_seg0), 32'hFD);

      // Mid-frame reset while digit 2 is shown
      i_en = 1'b1;
      i_code = 16'h0800;
      step();
      wait_frame("mid_rst_align");
      repeat (8) step();
      chk("mid_rst_dig2", 32'(o_an0), 32'hB);
      i_rst = 1'b1;
      step();
      chk("mid_rst_an", 32'(o_an0), 32'hF);
      chk("mid_rst_seg", 32'(o_seg0), 32'hFF);
      chk("mid_rst_code", 32'(o_code0), 32'd0);
      i_rst = 1'b0;
      step();
      chk("restart_an", 32'(o_an0), 32'hE);
      chk("restart_frame", 32'(o_frame0), 32'd1);
      wait_frame("restart_next");
      chk("restart_dig0_B", 32'(o_seg0), 32'hC1);
      repeat (4) step();
      chk("restart_dig1", 32'(o_seg0), 32'(LEAD_SEG));
      repeat (8) step();
      chk("restart_dig3", 32'(o_seg0), 32'(LEAD_SEG));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
